// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: counts rising edges of an asynchronous input over a fixed
// gate window and latches the total as packed BCD for the display multiplexer.
module freq_meter_bcd #(
  parameter int GATE_CYCLES = 100000000,
  parameter int DIGITS      = 8,
  parameter int CNT_W       = 27
) (
  input  logic                CLK_100MHz_i,
  input  logic                CLR_i,
  input  logic                SIG_IN_i,
  input  logic                HOLD_i,
  output logic [4*DIGITS-1:0] FREQ_BCD_o,
  output logic                OVF_o,
  output logic                VALID_o,
  output logic                GATE_o
);

  localparam logic [CNT_W-1:0] TC_VAL   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_VAL = CNT_W'(GATE_CYCLES / 2);

  logic                s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] freq_q, freq_d;
  logic [4*DIGITS-1:0] cntInc;
  logic                ovfSticky_q, ovfSticky_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                edgeDet, tc, allNines, carry;

  assign edgeDet = s2_q & ~s3_q;
  assign tc      = (t_q == TC_VAL);

  // Ripple-carry BCD increment; allNines flags the saturation case.
  always_comb begin
    carry    = 1'b1;
    allNines = 1'b1;
    cntInc   = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      allNines = allNines & (cnt_q[4*i +: 4] == 4'd9);
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cntInc[4*i +: 4] = 4'd0;
        end else begin
          cntInc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // The window-end transfer takes the count including this cycle's edge.
  always_comb begin
    t_d         = tc ? '0 : t_q + CNT_W'(1);
    cnt_d       = cnt_q;
    ovfSticky_d = ovfSticky_q;
    if (edgeDet) begin
      if (allNines) ovfSticky_d = 1'b1;
      else          cnt_d       = cntInc;
    end
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (tc) begin
      if (!HOLD_i) begin
        freq_d  = cnt_d;
        ovf_d   = ovfSticky_d;
        valid_d = 1'b1;
      end
      cnt_d       = '0;
      ovfSticky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_100MHz_i) begin
    if (CLR_i) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      t_q         <= '0;
      cnt_q       <= '0;
      ovfSticky_q <= 1'b0;
      freq_q      <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      s1_q        <= SIG_IN_i;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      ovfSticky_q <= ovfSticky_d;
      freq_q      <= freq_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
    end
  end

  assign FREQ_BCD_o = freq_q;
  assign OVF_o      = ovf_q;
  assign VALID_o    = valid_q;
  assign GATE_o     = (t_q < HALF_VAL);

endmodule

// File: doc/freq_meter_bcd.md
Name: freq_meter_bcd

Overview:
- Reciprocal of the 100 MHz-to-1 Hz divider: consumes a 1-second timebase and measures an unknown external square wave instead of generating one.
- Counts rising edges of asynchronous input SIG_IN over a gate window of exactly GATE_CYCLES clocks.
- At each window end, latches the count as packed BCD for the seven-segment display path.
- Sits between the board pin and the display multiplexer in the lab frequency-counter design.

Parameters:
- GATE_CYCLES, 100000000: gate window length in CLK_100MHz cycles; 1 s at 100 MHz. Must be 4 or greater.
- DIGITS, 8: number of BCD digits in the edge counter and result.
- CNT_W, 27: width of the internal gate-timer counter; must satisfy 2^CNT_W >= GATE_CYCLES.

Ports:
- CLK_100MHz  in  1  system clock; all logic on rising edge.
- CLR  in  1  synchronous reset, active-high.
- SIG_IN  in  1  measured signal; asynchronous to CLK_100MHz.
- HOLD  in  1  when 1, FREQ_BCD/OVF do not update at window end; measurement continues.
- FREQ_BCD  out  4*DIGITS  last latched result; digit 0 (units) in bits [3:0].
- OVF  out  1  result of last latched window saturated.
- VALID  out  1  one-cycle pulse when FREQ_BCD/OVF update.
- GATE  out  1  window indicator: 1 for the first floor(GATE_CYCLES/2) cycles of each window, else 0 (1 Hz LED).

Behaviour:
- Reset (CLR=1 at a clock edge):
  - FREQ_BCD=0, OVF=0, VALID=0.
  - Gate timer=0, edge counter=0, ovf_sticky=0.
  - Synchronizer and edge-detect flops=0.
  - GATE=1 on the first cycle after reset.
  - CLR mid-window abandons the partial count; no VALID is issued for it.
- Synchronizer:
  - SIG_IN passes through 2 flops (s1, s2), then a third flop s3.
  - edge = s2 & ~s3.
  - An SIG_IN rise is counted 3 clocks later.
  - Maximum countable frequency is below 50 MHz. Pulses narrower than 1 clock may be missed; this is accepted.
- Gate timer:
  - Counts 0..GATE_CYCLES-1 and wraps; t is its value.
  - Terminal cycle (TC): t == GATE_CYCLES-1.
  - Consecutive windows have no dead time.
- Edge counter:
  - DIGITS-digit synchronous BCD counter; each digit wraps 9->0 and carries when all lower digits are 9.
  - Increments by 1 on any cycle with edge=1.
  - If all digits are 9 and edge=1: holds all-9s and sets ovf_sticky=1 (saturate, no wrap).
- Window end, TC cycle (two-state FSM COUNT/LATCH is not used; the transfer happens in the TC cycle itself):
  - Result = counter value including this cycle's edge: count+1 if edge, saturated as above.
  - If HOLD=0: FREQ_BCD <= result, OVF <= ovf_sticky, or 1 if saturating in this cycle; VALID <= 1 next cycle.
  - If HOLD=1: FREQ_BCD, OVF and VALID are unchanged/0.
  - Edge counter <= 0 and ovf_sticky <= 0 in all cases. An edge on the cycle after TC counts as 1 in the new window.
- VALID:
  - Registered; high exactly the one cycle after a TC with HOLD=0; else 0.
- HOLD:
  - Sampled only on TC cycles.
  - Toggling HOLD mid-window has no effect until the next TC.
- Simultaneous CLR and TC: CLR wins; no VALID.
- All arithmetic is per-digit 4-bit BCD. No binary-to-BCD conversion in this block.

Test Plan:
- CLR for 3 cycles, SIG_IN=0 -> FREQ_BCD=0, OVF=0, VALID=0, GATE=1 on the cycle after CLR deasserts.
- GATE_CYCLES=1000, SIG_IN period 10 clk -> from the second window on, VALID pulses every 1000 cycles with FREQ_BCD=32'h00000100; GATE high for 500 cycles, low for 500.
- GATE_CYCLES=1000, SIG_IN period 3 clk (asynchronous phase) -> FREQ_BCD=0x333 or 0x334 each window; OVF=0; BCD digits never exceed 9.
- DIGITS=2, GATE_CYCLES=1000, SIG_IN period 4 clk -> FREQ_BCD=8'h99, OVF=1. Then SIG_IN period 20 clk -> next full window gives FREQ_BCD=8'h50, OVF=0.
- HOLD=1 across one TC while the frequency changes -> no VALID and FREQ_BCD unchanged at that TC. HOLD=0 -> next TC updates with the new window's count only.
- CLR asserted at t=500 with 49 edges counted -> outputs cleared. The next window starts at t=0 and reports a full-window count, not 49 plus the remainder.
